// File: rtl/pipe_stage_ctrl.sv
// Flow controller for the series-evaluation pipeline: per-stage hold/load selects,
// stage occupancy, valid/ready backpressure, drain/flush sequencing and sticky overflow.
module pipe_stage_ctrl #(
  parameter int STAGES = 4,
  parameter int OCC_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              ovf_out,
  input  logic              drain,
  input  logic              flush,
  input  logic              clr_ovf,
  output logic [STAGES-1:0] sel,
  output logic [STAGES-1:0] stage_v,
  output logic [OCC_W-1:0]  occ,
  output logic              drained,
  output logic              ovf_sticky,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; in_ready/out_valid never depend on in_valid/out_ready of the same side.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e              state_q;
  logic [STAGES-1:0]   stage_v_q;
  logic [STAGES-1:0]   stage_v_d;
  logic [OCC_W-1:0]    occ_q;
  logic [OCC_W-1:0]    occ_d;
  logic                drained_q;
  logic                ovf_q;
  logic [STAGES-1:0]   adv;
  logic                full_run;
  logic                drain_block;
  logic                accept;
  logic                retire;

  // A stage advances unless it and every stage after it are full with the sink stalled;
  // this lets bubbles collapse even while the last stage is held.
  always_comb begin
    full_run = 1'b1;
    adv      = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full_run = full_run & stage_v_q[k];
      adv[k]   = ~full_run | out_ready;
    end
  end

  assign drain_block = drain | (state_q == DRAIN);
  assign in_ready    = adv[0] & ~drain_block;
  assign out_valid   = stage_v_q[STAGES-1];
  assign accept      = in_valid & in_ready;
  assign retire      = out_valid & out_ready;

  always_comb begin
    stage_v_d    = stage_v_q;
    stage_v_d[0] = adv[0] ? (in_valid & ~drain_block) : stage_v_q[0];
    for (int k = 1; k < STAGES; k++) begin
      stage_v_d[k] = adv[k] ? stage_v_q[k-1] : stage_v_q[k];
    end
  end

  assign occ_d = occ_q + OCC_W'(accept) - OCC_W'(retire);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      stage_v_q <= '0;
      occ_q     <= '0;
      drained_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (flush) begin
      // Everything in flight is discarded; an active drain ends silently.
      state_q   <= IDLE;
      stage_v_q <= '0;
      occ_q     <= '0;
      drained_q <= 1'b0;
      if (clr_ovf) ovf_q <= 1'b0;
    end else begin
      stage_v_q <= stage_v_d;
      occ_q     <= occ_d;
      drained_q <= 1'b0;
      if (retire & ovf_out) ovf_q <= 1'b1;
      else if (clr_ovf)     ovf_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (drain)       drained_q <= 1'b1;
          else if (accept) state_q   <= RUN;
        end
        RUN: begin
          if (drain)              state_q <= DRAIN;
          else if (occ_d == '0)   state_q <= IDLE;
        end
        DRAIN: begin
          if (occ_d == '0) begin
            state_q   <= IDLE;
            drained_q <= 1'b1;
          end else if (!drain) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel        = adv;
  assign stage_v    = stage_v_q;
  assign occ        = occ_q;
  assign drained    = drained_q;
  assign ovf_sticky = ovf_q;
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl: drivers schedule hand-computed expectations
// into a queue keyed by cycle; a negedge monitor pops and compares them.
module tb_pipe_stage_ctrl;

  localparam int F_IN_READY = 0;
  localparam int F_OUT_V    = 1;
  localparam int F_SEL      = 2;
  localparam int F_STAGE_V  = 3;
  localparam int F_OCC      = 4;
  localparam int F_DRAINED  = 5;
  localparam int F_OVF      = 6;
  localparam int F_BUSY     = 7;
  localparam int F_STATE    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       ovf_out = 1'b0;
  logic       drain = 1'b0;
  logic       flush = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [3:0] sel;
  logic [3:0] stage_v;
  logic [2:0] occ;
  logic       drained;
  logic       ovf_sticky;
  logic       busy;
  logic [1:0] state_dbg;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int    cyc;
    int    fld;
    int    val;
    string nm;
  } exp_t;
  exp_t exp_q[$];
  exp_t keep_q[$];

  pipe_stage_ctrl #(.STAGES(4), .OCC_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .ovf_out(ovf_out),
    .drain(drain), .flush(flush), .clr_ovf(clr_ovf), .sel(sel),
    .stage_v(stage_v), .occ(occ), .drained(drained), .ovf_sticky(ovf_sticky),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock/reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int obs(int f);
    case (f)
      F_IN_READY: return int'(in_ready);
      F_OUT_V:    return int'(out_valid);
      F_SEL:      return int'(sel);
      F_STAGE_V:  return int'(stage_v);
      F_OCC:      return int'(occ);
      F_DRAINED:  return int'(drained);
      F_OVF:      return int'(ovf_sticky);
      F_BUSY:     return int'(busy);
      default:    return int'(state_dbg);
    endcase
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dly, input string nm, input int fld, input int val);
    exp_t e;
    e.cyc = cyc + dly;
    e.fld = fld;
    e.val = val;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    keep_q = {};
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc == cyc) begin
        total++;
        if (obs(exp_q[i].fld) != exp_q[i].val) begin
          bad++;
          $display("FAIL %s cyc=%0d actual=%0d expected=%0d", exp_q[i].nm, cyc,
                   obs(exp_q[i].fld), exp_q[i].val);
        end
      end else if (exp_q[i].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s stale cyc=%0d actual=unchecked expected=%0d", exp_q[i].nm,
                 exp_q[i].cyc, exp_q[i].val);
      end else begin
        keep_q.push_back(exp_q[i]);
      end
    end
    exp_q = keep_q;
  end

  initial begin
    repeat (2) step();
    rst = 1'b0;
    // reset state
    expect_at(0, "rst_stage_v", F_STAGE_V, 0);
    expect_at(0, "rst_occ", F_OCC, 0);
    expect_at(0, "rst_sel", F_SEL, 4'hF);
    expect_at(0, "rst_in_ready", F_IN_READY, 1);
    expect_at(0, "rst_out_valid", F_OUT_V, 0);
    expect_at(0, "rst_drained", F_DRAINED, 0);
    expect_at(0, "rst_ovf", F_OVF, 0);
    expect_at(0, "rst_busy", F_BUSY, 0);

    // single item latency
    in_valid = 1'b1; out_ready = 1'b1;
    expect_at(1, "lat_v1", F_STAGE_V, 4'b0001);
    for (int d = 1; d <= 4; d++) expect_at(d, "lat_occ", F_OCC, 1);
    for (int d = 1; d <= 3; d++) expect_at(d, "lat_out_v_lo", F_OUT_V, 0);
    expect_at(4, "lat_out_v_hi", F_OUT_V, 1);
    expect_at(4, "lat_v4", F_STAGE_V, 4'b1000);
    expect_at(5, "lat_occ_end", F_OCC, 0);
    expect_at(5, "lat_idle", F_BUSY, 0);
    step(); in_valid = 1'b0;
    repeat (5) step();

    // fill with sink stalled, then one retire with a new accept
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (4) step();
    expect_at(0, "full_in_ready", F_IN_READY, 0);
    expect_at(0, "full_sel", F_SEL, 4'b0000);
    expect_at(0, "full_occ", F_OCC, 4);
    step();
    out_ready = 1'b1;
    expect_at(0, "release_sel", F_SEL, 4'hF);
    expect_at(0, "release_in_ready", F_IN_READY, 1);
    expect_at(1, "release_occ", F_OCC, 4);
    expect_at(1, "release_v", F_STAGE_V, 4'hF);
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    expect_at(4, "empty_occ", F_OCC, 0);
    expect_at(4, "empty_idle", F_STATE, 0);
    repeat (4) step();

    // bubble collapse around a held last stage
    out_ready = 1'b0; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    repeat (2) step();
    in_valid = 1'b1;
    step(); in_valid = 1'b0;
    expect_at(0, "bub_v0", F_STAGE_V, 4'b1001);
    expect_at(0, "bub_sel", F_SEL, 4'b0111);
    expect_at(1, "bub_v1", F_STAGE_V, 4'b1010);
    expect_at(2, "bub_v2", F_STAGE_V, 4'b1100);
    expect_at(2, "bub_occ", F_OCC, 2);
    repeat (2) step();
    out_ready = 1'b1;
    expect_at(1, "bub_occ1", F_OCC, 1);
    expect_at(2, "bub_occ0", F_OCC, 0);
    repeat (2) step();

    // drain while idle
    drain = 1'b1;
    expect_at(0, "idle_drain_ready", F_IN_READY, 0);
    expect_at(1, "idle_drained", F_DRAINED, 1);
    expect_at(1, "idle_drain_state", F_STATE, 0);
    expect_at(2, "idle_drained_off", F_DRAINED, 0);
    step(); drain = 1'b0;
    step();

    // drain cancelled before empty returns to run
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (2) step();
    in_valid = 1'b0; drain = 1'b1;
    expect_at(1, "dcancel_drain", F_STATE, 2);
    expect_at(1, "dcancel_v", F_STAGE_V, 4'b0110);
    expect_at(2, "dcancel_run", F_STATE, 1);
    step(); drain = 1'b0;
    step();
    out_ready = 1'b1;
    repeat (4) step();

    // drain with three in flight
    in_valid = 1'b1;
    repeat (3) step();
    drain = 1'b1;
    expect_at(0, "drain_occ3", F_OCC, 3);
    expect_at(0, "drain_in_ready", F_IN_READY, 0);
    expect_at(1, "drain_state", F_STATE, 2);
    expect_at(1, "drain_v", F_STAGE_V, 4'b1110);
    expect_at(1, "drain_in_ready_blk", F_IN_READY, 0);
    expect_at(3, "drain_no_pulse_yet", F_DRAINED, 0);
    expect_at(4, "drain_occ0", F_OCC, 0);
    expect_at(4, "drain_pulse", F_DRAINED, 1);
    expect_at(4, "drain_idle", F_STATE, 0);
    expect_at(5, "drain_pulse_off", F_DRAINED, 0);
    repeat (4) step();
    drain = 1'b0; in_valid = 1'b0;
    repeat (2) step();

    // overflow set beats same-cycle clear
    in_valid = 1'b1;
    step(); in_valid = 1'b0;
    repeat (3) step();
    ovf_out = 1'b1; clr_ovf = 1'b1;
    expect_at(0, "ovf_out_valid", F_OUT_V, 1);
    expect_at(1, "ovf_set_wins", F_OVF, 1);
    step();
    ovf_out = 1'b0;
    expect_at(1, "ovf_cleared", F_OVF, 0);
    step(); clr_ovf = 1'b0;

    // flush full pipe during a stalled accept
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (4) step();
    out_ready = 1'b1; ovf_out = 1'b1;
    expect_at(1, "fl_occ_before", F_OCC, 4);
    expect_at(1, "fl_ovf_before", F_OVF, 1);
    step();
    out_ready = 1'b0; ovf_out = 1'b0; flush = 1'b1;
    expect_at(0, "fl_stalled", F_IN_READY, 0);
    expect_at(1, "fl_occ", F_OCC, 0);
    expect_at(1, "fl_v", F_STAGE_V, 0);
    expect_at(1, "fl_out_valid", F_OUT_V, 0);
    expect_at(1, "fl_ovf_kept", F_OVF, 1);
    expect_at(1, "fl_idle", F_STATE, 0);
    step(); flush = 1'b0; in_valid = 1'b0;
    step();

    // reset mid-operation
    in_valid = 1'b1;
    repeat (2) step();
    in_valid = 1'b0; rst = 1'b1;
    expect_at(0, "mid_occ_before", F_OCC, 2);
    expect_at(1, "mid_occ", F_OCC, 0);
    expect_at(1, "mid_v", F_STAGE_V, 0);
    expect_at(1, "mid_ovf", F_OVF, 0);
    expect_at(1, "mid_busy", F_BUSY, 0);
    expect_at(1, "mid_sel", F_SEL, 4'hF);
    expect_at(1, "mid_in_ready", F_IN_READY, 1);
    step(); rst = 1'b0;
    repeat (3) step();

    // final report
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expectations actual=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
